dbg_frame_tx: RTL and testbench

- Transmit side of the MicroBlaze debug link. It returns requested debug data to the processor over the 32-bit to-blaze frame.
- It accepts one wide debug snapshot per request (latch contents, register, memory word, PC) and sends it as a header frame followed by 32-bit data words.
- Each frame is advanced by a one-cycle ack from the blaze side.
- It sits between the debug controllers' data mux and the pipeline's o_frame_to_blaze output.

---
 rtl/dbg_frame_tx.sv | 182 ++++++++++++++++++
 tb/tb_dbg_frame_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_frame_tx.sv
// Debug-link transmitter: sends a header frame then up to MAX_WORDS snapshot words, one per blaze ack.
// Optional ack watchdog enabled by defining DBG_TX_TIMEOUT_EN.
module dbg_frame_tx #(
    parameter int NB_CONTROL_FRAME = 32,
    parameter int NB_DATA_MAX      = 96,
    parameter int NB_ID            = 6,
    parameter int NB_WCNT          = 4,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_req_valid,
    output logic                        o_req_ready,
    input  logic [NB_ID-1:0]            i_req_id,
    input  logic [NB_WCNT-1:0]          i_req_nwords,
    input  logic [NB_DATA_MAX-1:0]      i_req_data,
    input  logic                        i_ack,
    output logic [NB_CONTROL_FRAME-1:0] o_frame_to_blaze,
    output logic                        o_frame_valid,
    output logic                        o_done
);
    localparam int MAX_WORDS = (NB_DATA_MAX + NB_CONTROL_FRAME - 1) / NB_CONTROL_FRAME;
    localparam int NB_IDX    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int NB_PAD    = MAX_WORDS * NB_CONTROL_FRAME;

    typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_DATA, ST_DONE} state_t;

    state_t                      state_q, state_d;
    logic [NB_ID-1:0]            id_q, id_d;
    logic [NB_WCNT-1:0]          nwords_q, nwords_d;
    logic [NB_DATA_MAX-1:0]      data_q, data_d;
    logic [NB_IDX-1:0]           idx_q, idx_d;
    logic [NB_CONTROL_FRAME-1:0] frame_q, frame_d;
    logic                        valid_q, valid_d;
    logic                        done_q, done_d;

    logic                        accept;
    logic [NB_WCNT-1:0]          req_nwords_eff;
    logic [NB_IDX-1:0]           idx_inc;
    logic                        last_word;
    logic [NB_PAD-1:0]           data_pad;
    logic [NB_CONTROL_FRAME-1:0] words [MAX_WORDS];

    // Zero-extend the snapshot so every word slot, including a partial top word, is defined.
    assign data_pad = NB_PAD'(data_q);

    generate
        for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_word
            assign words[gi] = data_pad[gi*NB_CONTROL_FRAME +: NB_CONTROL_FRAME];
        end
    endgenerate

    assign o_req_ready    = (state_q == ST_IDLE);
    assign accept         = i_req_valid && o_req_ready;
    assign req_nwords_eff = (i_req_nwords > NB_WCNT'(MAX_WORDS)) ? NB_WCNT'(MAX_WORDS) : i_req_nwords;
    assign idx_inc        = idx_q + NB_IDX'(1);
    assign last_word      = (NB_WCNT'(idx_q) + NB_WCNT'(1)) == nwords_q;

`ifdef DBG_TX_TIMEOUT_EN
    localparam int NB_TMO = $clog2(TIMEOUT_CYCLES + 1);
    logic [NB_TMO-1:0] tmo_q, tmo_d;
    logic              tmo_hit;

    assign tmo_hit = (state_q == ST_HEADER || state_q == ST_DATA) && !i_ack
                     && (tmo_q == NB_TMO'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = '0;
        if ((state_q == ST_HEADER || state_q == ST_DATA) && !i_ack) begin
            tmo_d = tmo_q + NB_TMO'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic tmo_hit;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        nwords_d = nwords_q;
        data_d   = data_q;
        idx_d    = idx_q;
        frame_d  = frame_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                frame_d = '0;
                valid_d = 1'b0;
                if (accept) begin
                    state_d  = ST_HEADER;
                    id_d     = i_req_id;
                    nwords_d = req_nwords_eff;
                    data_d   = i_req_data;
                    idx_d    = '0;
                    frame_d  = NB_CONTROL_FRAME'({i_req_id, 1'b1, 9'(req_nwords_eff), 16'h0000});
                    valid_d  = 1'b1;
                end
            end
            ST_HEADER: begin
                if (i_ack) begin
                    if (nwords_q == '0) begin
                        state_d = ST_DONE;
                        frame_d = '0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                        frame_d = words[0];
                    end
                end
            end
            ST_DATA: begin
                if (i_ack) begin
                    if (last_word) begin
                        state_d = ST_DONE;
                        frame_d = '0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_inc;
                        frame_d = words[idx_inc];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                frame_d = '0;
                valid_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                frame_d = '0;
                valid_d = 1'b0;
            end
        endcase
        // A watchdog abort reports itself with an all-ones marker alongside the done pulse.
        if (tmo_hit) begin
            state_d = ST_DONE;
            frame_d = '1;
            valid_d = 1'b1;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            id_q     <= '0;
            nwords_q <= '0;
            data_q   <= '0;
            idx_q    <= '0;
            frame_q  <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            nwords_q <= nwords_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign o_frame_to_blaze = frame_q;
    assign o_frame_valid    = valid_q;
    assign o_done           = done_q;

endmodule

// File: tb/tb_dbg_frame_tx.sv
// Scoreboard bench for dbg_frame_tx: stimulus queues expected frames/done, a monitor checks each acked frame.
module tb_dbg_frame_tx;
    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [5:0]  i_req_id;
    logic [3:0]  i_req_nwords;
    logic [95:0] i_req_data;
    logic        i_ack;
    logic [31:0] o_frame_to_blaze;
    logic        o_frame_valid;
    logic        o_done;

    always #5 i_clock = ~i_clock;

    dbg_frame_tx dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .i_req_valid      (i_req_valid),
        .o_req_ready      (o_req_ready),
        .i_req_id         (i_req_id),
        .i_req_nwords     (i_req_nwords),
        .i_req_data       (i_req_data),
        .i_ack            (i_ack),
        .o_frame_to_blaze (o_frame_to_blaze),
        .o_frame_valid    (o_frame_valid),
        .o_done           (o_done)
    );

    typedef struct packed {
        logic        is_done;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endfunction

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic expect_frame(input logic [31:0] v);
        exp_q.push_back({1'b0, v});
    endtask

    task automatic expect_done();
        exp_q.push_back({1'b1, 32'h0});
    endtask

    task automatic expect_words(input logic [95:0] d, input int n);
        for (int k = 0; k < n; k++) expect_frame(d[32*k +: 32]);
    endtask

    // Drive one request for a single cycle, then check the header shows up one cycle later.
    task automatic send_req(input logic [5:0] id, input logic [3:0] n, input logic [95:0] d,
                            input logic [31:0] hdr);
        int w;
        w = 0;
        while (!o_req_ready && w < 20) begin
            step();
            w++;
        end
        if (!o_req_ready) check("req_ready_wait", {31'b0, o_req_ready}, 32'd1);
        i_req_valid  = 1'b1;
        i_req_id     = id;
        i_req_nwords = n;
        i_req_data   = d;
        step();
        i_req_valid  = 1'b0;
        check("hdr_latency_valid", {31'b0, o_frame_valid}, 32'd1);
        check("hdr_latency_frame", o_frame_to_blaze, hdr);
        $display("request id=%b nwords=%0d accepted, header %h", id, n, o_frame_to_blaze);
    endtask

    task automatic ack_once();
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
    endtask

    // Monitor: every acked frame and every done pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clock);
            if (o_frame_valid && i_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", o_frame_to_blaze, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_kind", {31'b0, e.is_done}, 32'd0);
                    check("frame", o_frame_to_blaze, e.val);
                    $display("frame %h acked (expected %h)", o_frame_to_blaze, e.val);
                end
            end
            if (o_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {31'b0, o_done}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_kind", {31'b0, e.is_done}, 32'd1);
                    check("done_frame", o_frame_to_blaze, 32'h0);
                    check("done_valid", {31'b0, o_frame_valid}, 32'd0);
                    $display("done pulse seen");
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset      = 1'b0;
        i_req_valid  = 1'b1;
        i_req_id     = 6'b100110;
        i_req_nwords = 4'd3;
        i_req_data   = 96'h1;
        i_ack        = 1'b0;

        // Reset held with a request pending: nothing may be accepted.
        step();
        step();
        check("rst_valid", {31'b0, o_frame_valid}, 32'd0);
        check("rst_frame", o_frame_to_blaze, 32'h0);
        check("rst_ready", {31'b0, o_req_ready}, 32'd1);
        check("rst_done",  {31'b0, o_done}, 32'd0);
        i_req_valid = 1'b0;
        i_reset     = 1'b1;
        step();
        check("idle_valid", {31'b0, o_frame_valid}, 32'd0);

        // Decode-latch readout with gaps between acks; inputs are disturbed after accept.
        expect_frame(32'h9A03_0000);
        expect_frame(32'h1234_5678);
        expect_frame(32'hCAFE_BABE);
        expect_frame(32'h0000_0015);
        expect_done();
        send_req(6'b100110, 4'd3, 96'h0000_0015_CAFE_BABE_1234_5678, 32'h9A03_0000);
        i_req_data   = 96'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
        i_req_id     = 6'h3F;
        i_req_nwords = 4'd1;
        i_req_valid  = 1'b1;
        ack_once();
        step();
        check("busy_ready", {31'b0, o_req_ready}, 32'd0);
        check("stable_word0", o_frame_to_blaze, 32'h1234_5678);
        ack_once();
        step();
        ack_once();
        i_req_valid = 1'b0;
        step();
        ack_once();
        check("decode_done_pulse", {31'b0, o_done}, 32'd1);
        step();
        check("decode_done_width", {31'b0, o_done}, 32'd0);
        check("decode_idle_ready", {31'b0, o_req_ready}, 32'd1);

        // Clamp nwords=7 to 3 with ack held high continuously.
        expect_frame(32'h0E03_0000);
        expect_words(96'h3333_3333_2222_2222_1111_1111, 3);
        expect_done();
        send_req(6'b000011, 4'd7, 96'h3333_3333_2222_2222_1111_1111, 32'h0E03_0000);
        i_ack = 1'b1;
        step();
        step();
        step();
        step();
        check("clamp_done_latency", {31'b0, o_done}, 32'd1);
        i_ack = 1'b0;
        step();

        // Zero-word request: header only.
        expect_frame(32'h8600_0000);
        expect_done();
        send_req(6'b100001, 4'd0, 96'hFFFF_0000_FFFF_0000_FFFF_0000, 32'h8600_0000);
        ack_once();
        check("zero_done_pulse", {31'b0, o_done}, 32'd1);
        step();

        // Spurious ack while idle.
        i_ack = 1'b1;
        step();
        step();
        check("spur_valid", {31'b0, o_frame_valid}, 32'd0);
        check("spur_frame", o_frame_to_blaze, 32'h0);
        check("spur_ready", {31'b0, o_req_ready}, 32'd1);
        check("spur_done",  {31'b0, o_done}, 32'd0);
        i_ack = 1'b0;
        step();

        // Reset in the middle of DATA at idx=1.
        expect_frame(32'h0603_0000);
        expect_frame(32'h0A0A_0A0A);
        send_req(6'b000001, 4'd3, 96'h0C0C_0C0C_0B0B_0B0B_0A0A_0A0A, 32'h0603_0000);
        ack_once();
        ack_once();
        check("mid_word1", o_frame_to_blaze, 32'h0B0B_0B0B);
        #2;
        i_reset = 1'b0;
        #1;
        check("abort_valid", {31'b0, o_frame_valid}, 32'd0);
        check("abort_frame", o_frame_to_blaze, 32'h0);
        check("abort_ready", {31'b0, o_req_ready}, 32'd1);
        step();
        step();
        check("abort_no_done", {31'b0, o_done}, 32'd0);
        i_reset = 1'b1;
        step();

        // Fresh request after the abort.
        expect_frame(32'h0A01_0000);
        expect_frame(32'h5555_AAAA);
        expect_done();
        send_req(6'b000010, 4'd1, 96'h7777_7777_6666_6666_5555_AAAA, 32'h0A01_0000);
        ack_once();
        ack_once();
        check("fresh_done_pulse", {31'b0, o_done}, 32'd1);
        step();
        step();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
